cpu_hazard_scoreboard: RTL and testbench
========================================

Name: cpu_hazard_scoreboard

Overview:
Successor to the 5-stage pipeline hazard unit, generalised for variable-latency execution. Adds the following on top of M/W forwarding, load-use stall and branch flush:
- a per-register pending scoreboard for out-of-band multi-cycle ops (MUL/DIV) with up to MAX_OUTSTANDING in flight;
- a memory-wait freeze of the whole pipe.
Sits beside the datapath, driving the pipeline register enables/clears and the E-stage forwarding muxes.

Parameters:
REG_ADDR_W, 5, register index width; scoreboard has 2**REG_ADDR_W entries, entry 0 never set.
MAX_OUTSTANDING, 2, max multi-cycle ops in flight (1..2**REG_ADDR_W-1).
CNT_W, $clog2(MAX_OUTSTANDING+1), width of outstanding counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
rs1_d, rs2_d, rd_d  in  REG_ADDR_W  D-stage register indices.
reg_write_d  in  1  D instruction writes rd.
mc_op_d  in  1  D instruction is multi-cycle.
rs1_e, rs2_e, rd_e  in  REG_ADDR_W  E-stage indices.
pc_src_e  in  2  PC source; != PC_SRC_PC_PLUS_4 means redirect.
result_src_e  in  2  RESULT_SRC_DATA means load.
mc_issue_e  in  1  E instruction is dispatched to the multi-cycle unit this cycle.
reg_write_m  in  1; rd_m  in  REG_ADDR_W.
mem_wait_m  in  1  data bus not ready; M must hold.
reg_write_w  in  1; rd_w  in  REG_ADDR_W.
mc_done  in  1  multi-cycle unit writes result this cycle.
mc_rd  in  REG_ADDR_W  destination of completing op.
forward_a_e, forward_b_e  out  2  FORWARD_NONE/MEMORY/WRITEBACK.
stall_f, stall_d, stall_e, stall_m  out  1  hold stage register.
flush_d, flush_e, flush_w  out  1  insert bubble.
mc_outstanding  out  CNT_W  registered in-flight count.
sb_error  out  1  sticky: mc_done for non-pending register.

Behaviour:
- Reset: scoreboard all 0, mc_outstanding=0, sb_error=0. Combinational outputs follow the zeroed state.
- Forwarding: combinational, M priority over W, index 0 never forwarded; encodings unchanged from the existing hazard unit.
- Terms (all combinational):
  - pend(r) = scoreboard[r] && r!=0.
  - raw_sb = pend(rs1_d) || pend(rs2_d).
  - waw_sb = reg_write_d && pend(rd_d).
  - e_hz = (result_src_e==RESULT_SRC_DATA || mc_issue_e) && rd_e!=0 && (rs1_d==rd_e || rs2_d==rd_e).
  - struct = mc_op_d && (mc_outstanding + (mc_issue_e && !mem_wait_m) - mc_done_valid) >= MAX_OUTSTANDING, where mc_done_valid = mc_done && pend(mc_rd).
  - d_stall = raw_sb || waw_sb || e_hz || struct.
  - redirect = pc_src_e != PC_SRC_PC_PLUS_4.
- mem_wait_m=1 dominates everything:
  - stall_f=stall_d=stall_e=stall_m=1, flush_w=1;
  - flush_d=flush_e=0, even on redirect (redirect re-evaluated when wait drops).
- mem_wait_m=0:
  - stall_f=stall_d=d_stall; stall_e=stall_m=flush_w=0;
  - flush_d=redirect;
  - flush_e=redirect || d_stall.
- Scoreboard update, rising clk when !rst:
  - clear scoreboard[mc_rd] if mc_done_valid;
  - then set scoreboard[rd_e] if mc_issue_e && !mem_wait_m && rd_e!=0 (set wins on same index).
  - mc_done is accepted during mem_wait_m.
- Counter: +1 on qualified issue, -1 on mc_done_valid, unchanged when both. Never wraps: issue at MAX_OUTSTANDING is prevented by struct.
  - Issue with rd_e==0 still counts; the unit must still report mc_done for it with mc_rd=0. Such a done decrements regardless of pend.
- mc_done with mc_rd!=0 and bit clear: no state change, sb_error<=1 until rst.
- rst mid-operation: scoreboard and counter cleared next edge; late mc_done then sets sb_error.

Optional Feature:
CPU_HAZARD_PERF_EN: adds outputs perf_stall_cycles[31:0] and perf_flush_cycles[31:0].
- perf_stall_cycles: +1 per cycle stall_f=1.
- perf_flush_cycles: +1 per cycle flush_d||flush_e.
- Both wrap at 2**32, cleared by rst.
Without the macro, ports absent and no counter logic synthesised.

Test Plan:
- Forwarding: rs1_e=5, rd_m=5, reg_write_m=1, and rd_w=5, reg_write_w=1 -> forward_a_e=MEMORY. rs2_e=0 with rd_m=0 -> FORWARD_NONE.
- MC RAW: issue mc_issue_e rd_e=7 -> next cycle scoreboard[7]=1, mc_outstanding=1. D with rs2_d=7 -> stall_f=stall_d=flush_e=1 until mc_done mc_rd=7. The following cycle the stall drops.
- Structural: MAX_OUTSTANDING=2, two issues (rd 3,4) outstanding, mc_op_d=1 -> stall. Same cycle mc_done mc_rd=3 -> struct clears that cycle, count stays 2 after the new issue.
- Mem freeze: mem_wait_m=1 for 3 cycles with pc_src_e redirect and mc_issue_e=1 -> all stalls=1, flush_w=1, flush_d=flush_e=0, no scoreboard set. Redirect flush and issue both occur in the cycle wait drops.
- Error/reset: mc_done mc_rd=9 with bit clear -> sb_error=1, count unchanged. rst -> sb_error=0, count=0, all bits clear.
- PERF (macro on): 4 load-use stall cycles + 1 redirect -> perf_stall_cycles=4, perf_flush_cycles=5.

Source files
------------

// File: rtl/cpu_hazard_scoreboard.sv
// Pipeline hazard unit with M/W forwarding, load-use and multi-cycle RAW/WAW stalls, branch flush and memory-wait freeze.
// Optional perf counters: define CPU_HAZARD_PERF_EN to add perf_stall_cycles / perf_flush_cycles.
module cpu_hazard_scoreboard #(
    parameter int REG_ADDR_W      = 5,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  reg_write_d,
    input  logic                  mc_op_d,
    input  logic [REG_ADDR_W-1:0] rs1_e,
    input  logic [REG_ADDR_W-1:0] rs2_e,
    input  logic [REG_ADDR_W-1:0] rd_e,
    input  logic [1:0]            pc_src_e,
    input  logic [1:0]            result_src_e,
    input  logic                  mc_issue_e,
    input  logic                  reg_write_m,
    input  logic [REG_ADDR_W-1:0] rd_m,
    input  logic                  mem_wait_m,
    input  logic                  reg_write_w,
    input  logic [REG_ADDR_W-1:0] rd_w,
    input  logic                  mc_done,
    input  logic [REG_ADDR_W-1:0] mc_rd,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  flush_w,
    output logic [CNT_W-1:0]      mc_outstanding,
    output logic                  sb_error
`ifdef CPU_HAZARD_PERF_EN
   ,output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_cycles
`endif
);

    localparam logic [1:0] FORWARD_NONE      = 2'b00;
    localparam logic [1:0] FORWARD_WRITEBACK = 2'b01;
    localparam logic [1:0] FORWARD_MEMORY    = 2'b10;
    localparam logic [1:0] PC_SRC_PC_PLUS_4  = 2'b00;
    localparam logic [1:0] RESULT_SRC_DATA   = 2'b01;
    localparam int         NUM_REGS          = 2 ** REG_ADDR_W;

    logic [NUM_REGS-1:0] sb_q;
    logic [NUM_REGS-1:0] sb_d;
    logic [NUM_REGS-1:0] pend;
    logic [CNT_W-1:0]    cnt_q;
    logic                sb_error_q;

    logic             issue_q;
    logic             mc_rd_zero;
    logic             done_valid;
    logic             done_bogus;
    logic [CNT_W:0]   cnt_next_ext;
    logic [CNT_W:0]   cnt_limit;
    logic             raw_sb;
    logic             waw_sb;
    logic             e_hz;
    logic             struct_hz;
    logic             d_stall;
    logic             redirect;

    // Register 0 is hard-wired, so it can never be reported pending.
    assign pend       = {sb_q[NUM_REGS-1:1], 1'b0};
    assign issue_q    = mc_issue_e && !mem_wait_m;
    assign mc_rd_zero = (mc_rd == '0);
    // Ops targeting x0 carry no scoreboard bit; they only retire a count.
    assign done_valid = mc_done && (mc_rd_zero ? (cnt_q != '0) : sb_q[mc_rd]);
    assign done_bogus = mc_done && !mc_rd_zero && !sb_q[mc_rd];

    assign raw_sb = pend[rs1_d] || pend[rs2_d];
    assign waw_sb = reg_write_d && pend[rd_d];
    assign e_hz   = ((result_src_e == RESULT_SRC_DATA) || mc_issue_e) && (rd_e != '0)
                    && ((rs1_d == rd_e) || (rs2_d == rd_e));

    // count + issue - done >= MAX, rearranged so nothing underflows.
    assign cnt_next_ext = {1'b0, cnt_q} + (CNT_W+1)'(issue_q);
    assign cnt_limit    = (CNT_W+1)'(MAX_OUTSTANDING) + (CNT_W+1)'(done_valid);
    assign struct_hz    = mc_op_d && (cnt_next_ext >= cnt_limit);

    assign d_stall  = raw_sb || waw_sb || e_hz || struct_hz;
    assign redirect = (pc_src_e != PC_SRC_PC_PLUS_4);

    always_comb begin
        forward_a_e = FORWARD_NONE;
        forward_b_e = FORWARD_NONE;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))
            forward_a_e = FORWARD_MEMORY;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e))
            forward_a_e = FORWARD_WRITEBACK;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))
            forward_b_e = FORWARD_MEMORY;
        else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e))
            forward_b_e = FORWARD_WRITEBACK;
    end

    // A memory wait freezes everything; a pending redirect waits for the wait to drop.
    always_comb begin
        stall_f = d_stall;
        stall_d = d_stall;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = redirect;
        flush_e = redirect || d_stall;
        flush_w = 1'b0;
        if (mem_wait_m) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_d = 1'b0;
            flush_e = 1'b0;
            flush_w = 1'b1;
        end
    end

    // Clear first so a same-index issue leaves the bit set.
    always_comb begin
        sb_d = sb_q;
        if (done_valid && !mc_rd_zero)
            sb_d[mc_rd] = 1'b0;
        if (issue_q && (rd_e != '0))
            sb_d[rd_e] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q       <= '0;
            cnt_q      <= '0;
            sb_error_q <= 1'b0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_q + CNT_W'(issue_q) - CNT_W'(done_valid);
            if (done_bogus)
                sb_error_q <= 1'b1;
        end
    end

    assign mc_outstanding = cnt_q;
    assign sb_error       = sb_error_q;

`ifdef CPU_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_cycles <= '0;
        end else begin
            if (stall_f)
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (flush_d || flush_e)
                perf_flush_cycles <= perf_flush_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_hazard_scoreboard.sv
// Self-checking bench for cpu_hazard_scoreboard: vector table, directed multi-cycle sequences,
// and randomized traffic against an in-flight-queue reference model.
module tb_cpu_hazard_scoreboard;

    localparam int AW   = 5;
    localparam int MAXO = 2;
    localparam int CW   = 2;
    localparam logic [1:0] F_NONE = 2'b00;
    localparam logic [1:0] F_WB   = 2'b01;
    localparam logic [1:0] F_MEM  = 2'b10;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rs1_d, rs2_d, rd_d;
    logic          reg_write_d, mc_op_d;
    logic [AW-1:0] rs1_e, rs2_e, rd_e;
    logic [1:0]    pc_src_e, result_src_e;
    logic          mc_issue_e;
    logic          reg_write_m;
    logic [AW-1:0] rd_m;
    logic          mem_wait_m;
    logic          reg_write_w;
    logic [AW-1:0] rd_w;
    logic          mc_done;
    logic [AW-1:0] mc_rd;
    logic [1:0]    forward_a_e, forward_b_e;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, flush_w;
    logic [CW-1:0] mc_outstanding;
    logic          sb_error;
`ifdef CPU_HAZARD_PERF_EN
    logic [31:0]   perf_stall_cycles, perf_flush_cycles;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    logic [13:0] exp_q[$];
    int inflight[$];
    bit err_m;

    cpu_hazard_scoreboard #(.REG_ADDR_W(AW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .reg_write_d(reg_write_d), .mc_op_d(mc_op_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .pc_src_e(pc_src_e),
        .result_src_e(result_src_e), .mc_issue_e(mc_issue_e),
        .reg_write_m(reg_write_m), .rd_m(rd_m), .mem_wait_m(mem_wait_m),
        .reg_write_w(reg_write_w), .rd_w(rd_w), .mc_done(mc_done), .mc_rd(mc_rd),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .mc_outstanding(mc_outstanding), .sb_error(sb_error)
`ifdef CPU_HAZARD_PERF_EN
       ,.perf_stall_cycles(perf_stall_cycles), .perf_flush_cycles(perf_flush_cycles)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] rs1_d, rs2_d, rd_d;
        logic          reg_write_d, mc_op_d;
        logic [AW-1:0] rs1_e, rs2_e, rd_e;
        logic [1:0]    pc_src_e, result_src_e;
        logic          mc_issue_e, reg_write_m;
        logic [AW-1:0] rd_m;
        logic          mem_wait_m, reg_write_w;
        logic [AW-1:0] rd_w;
        logic [1:0]    exp_fa, exp_fb;
        logic [6:0]    exp_ctl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t blank();
        vec_t v;
        v.rs1_d = 0; v.rs2_d = 0; v.rd_d = 0; v.reg_write_d = 0; v.mc_op_d = 0;
        v.rs1_e = 0; v.rs2_e = 0; v.rd_e = 0; v.pc_src_e = 0; v.result_src_e = 0;
        v.mc_issue_e = 0; v.reg_write_m = 0; v.rd_m = 0; v.mem_wait_m = 0;
        v.reg_write_w = 0; v.rd_w = 0; v.exp_fa = F_NONE; v.exp_fb = F_NONE; v.exp_ctl = 7'b0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rs1_d = 0; rs2_d = 0; rd_d = 0; reg_write_d = 0; mc_op_d = 0;
        rs1_e = 0; rs2_e = 0; rd_e = 0; pc_src_e = 0; result_src_e = 0; mc_issue_e = 0;
        reg_write_m = 0; rd_m = 0; mem_wait_m = 0; reg_write_w = 0; rd_w = 0;
        mc_done = 0; mc_rd = 0;
    endtask

    task automatic apply_vec(input vec_t v);
        idle();
        rs1_d = v.rs1_d; rs2_d = v.rs2_d; rd_d = v.rd_d; reg_write_d = v.reg_write_d;
        mc_op_d = v.mc_op_d; rs1_e = v.rs1_e; rs2_e = v.rs2_e; rd_e = v.rd_e;
        pc_src_e = v.pc_src_e; result_src_e = v.result_src_e; mc_issue_e = v.mc_issue_e;
        reg_write_m = v.reg_write_m; rd_m = v.rd_m; mem_wait_m = v.mem_wait_m;
        reg_write_w = v.reg_write_w; rd_w = v.rd_w;
    endtask

    function automatic logic [6:0] ctl_act();
        return {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w};
    endfunction

    function automatic logic [13:0] out_act();
        return {forward_a_e, forward_b_e, ctl_act(), mc_outstanding, sb_error};
    endfunction

    // Reference model: in-flight ops are a list of destination registers.
    function automatic bit in_flight(input int r);
        foreach (inflight[i]) if (inflight[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pend_m(input int r);
        return (r != 0) && in_flight(r);
    endfunction

    function automatic logic [1:0] fwd_m(input int rs);
        if (reg_write_m && rd_m != 0 && int'(rd_m) == rs) return F_MEM;
        if (reg_write_w && rd_w != 0 && int'(rd_w) == rs) return F_WB;
        return F_NONE;
    endfunction

    function automatic logic [13:0] model_expect();
        bit dv, stall, redir, ehz, str;
        int after;
        logic [6:0] ctl;
        dv    = mc_done && in_flight(int'(mc_rd));
        after = inflight.size() + int'(mc_issue_e && !mem_wait_m) - int'(dv);
        str   = mc_op_d && (after >= MAXO);
        ehz   = (result_src_e == 2'b01 || mc_issue_e) && rd_e != 0 && (rs1_d == rd_e || rs2_d == rd_e);
        stall = pend_m(int'(rs1_d)) || pend_m(int'(rs2_d)) || (reg_write_d && pend_m(int'(rd_d)))
                || ehz || str;
        redir = (pc_src_e != 2'b00);
        if (mem_wait_m) ctl = 7'b1111001;
        else            ctl = {stall, stall, 2'b00, redir, redir || stall, 1'b0};
        return {fwd_m(int'(rs1_e)), fwd_m(int'(rs2_e)), ctl, CW'(inflight.size()), err_m};
    endfunction

    task automatic model_update();
        bit found;
        if (rst) begin
            inflight.delete();
            err_m = 1'b0;
        end else begin
            found = 1'b0;
            if (mc_done) begin
                foreach (inflight[i]) begin
                    if (!found && inflight[i] == int'(mc_rd)) begin
                        inflight.delete(i);
                        found = 1'b1;
                    end
                end
                if (!found && mc_rd != 0) err_m = 1'b1;
            end
            if (mc_issue_e && !mem_wait_m) inflight.push_back(int'(rd_e));
        end
    endtask

    task automatic random_cycle(input int n);
        int r;
        logic [13:0] e;
        idle();
        rst = ($urandom_range(0, 99) == 0);
        rs1_d = AW'($urandom_range(0, 7)); rs2_d = AW'($urandom_range(0, 7));
        rd_d = AW'($urandom_range(0, 7)); reg_write_d = 1'($urandom_range(0, 1));
        mc_op_d = 1'($urandom_range(0, 1));
        rs1_e = AW'($urandom_range(0, 7)); rs2_e = AW'($urandom_range(0, 7));
        pc_src_e = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        result_src_e = 2'($urandom_range(0, 3));
        reg_write_m = 1'($urandom_range(0, 1)); rd_m = AW'($urandom_range(0, 7));
        reg_write_w = 1'($urandom_range(0, 1)); rd_w = AW'($urandom_range(0, 7));
        mem_wait_m = ($urandom_range(0, 4) == 0);
        if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
            mc_done = 1'b1;
            mc_rd = AW'(inflight[$urandom_range(0, inflight.size() - 1)]);
        end else if ($urandom_range(0, 39) == 0) begin
            do r = $urandom_range(1, 31); while (in_flight(r));
            mc_done = 1'b1;
            mc_rd = AW'(r);
        end else begin
            mc_rd = AW'($urandom_range(0, 31));
        end
        if (inflight.size() < MAXO && $urandom_range(0, 2) == 0) begin
            mc_issue_e = 1'b1;
            if ($urandom_range(0, 7) == 0) r = 0;
            else do r = $urandom_range(1, 7); while (in_flight(r));
            rd_e = AW'(r);
        end else begin
            rd_e = AW'($urandom_range(0, 7));
        end
        #2;
        exp_q.push_back(model_expect());
        e = exp_q.pop_front();
        check($sformatf("rand_cycle%0d", n), 32'(out_act()), 32'(e));
        tick();
        model_update();
    endtask

    initial begin
        vec_t v;
        idle();
        rst = 1'b1;
        tick();
        tick();
        check("reset_outputs", 32'(out_act()), 32'h0);

        // Vector table; held in reset so the scoreboard stays empty.
        v = blank(); v.rs1_e = 5; v.rd_m = 5; v.reg_write_m = 1; v.rd_w = 5; v.reg_write_w = 1;
        v.exp_fa = F_MEM; vecs.push_back(v);
        v = blank(); v.rs1_e = 6; v.rs2_e = 6; v.rd_m = 5; v.reg_write_m = 1; v.rd_w = 6;
        v.reg_write_w = 1; v.exp_fa = F_WB; v.exp_fb = F_WB; vecs.push_back(v);
        v = blank(); v.reg_write_m = 1; v.reg_write_w = 1; vecs.push_back(v);
        v = blank(); v.rs1_e = 5; v.rd_m = 5; v.rd_w = 5; v.reg_write_w = 1; v.exp_fa = F_WB;
        vecs.push_back(v);
        v = blank(); v.rs2_e = 9; v.rd_m = 9; v.reg_write_m = 1; v.exp_fb = F_MEM; vecs.push_back(v);
        v = blank(); v.result_src_e = 2'b01; v.rd_e = 3; v.rs1_d = 3; v.exp_ctl = 7'b1100010;
        vecs.push_back(v);
        v = blank(); v.result_src_e = 2'b01; vecs.push_back(v);
        v = blank(); v.mc_issue_e = 1; v.rd_e = 4; v.rs2_d = 4; v.exp_ctl = 7'b1100010;
        vecs.push_back(v);
        v = blank(); v.pc_src_e = 2'b01; v.exp_ctl = 7'b0000110; vecs.push_back(v);
        v = blank(); v.pc_src_e = 2'b10; v.result_src_e = 2'b01; v.rd_e = 3; v.rs2_d = 3;
        v.exp_ctl = 7'b1100110; vecs.push_back(v);
        v = blank(); v.mem_wait_m = 1; v.pc_src_e = 2'b01; v.result_src_e = 2'b01; v.rd_e = 3;
        v.rs1_d = 3; v.exp_ctl = 7'b1111001; vecs.push_back(v);
        v = blank(); v.mem_wait_m = 1; v.exp_ctl = 7'b1111001; vecs.push_back(v);
        v = blank(); v.mc_op_d = 1; v.mc_issue_e = 1; v.rd_e = 9; v.rs1_d = 1; v.rs2_d = 2;
        vecs.push_back(v);
        v = blank(); v.reg_write_d = 1; v.rd_d = 12; vecs.push_back(v);

        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            #2;
            check($sformatf("vec%0d_fwd_a", i), 32'(forward_a_e), 32'(vecs[i].exp_fa));
            check($sformatf("vec%0d_fwd_b", i), 32'(forward_b_e), 32'(vecs[i].exp_fb));
            check($sformatf("vec%0d_ctl", i), 32'(ctl_act()), 32'(vecs[i].exp_ctl));
            tick();
        end
        idle();
        rst = 1'b0;
        tick();

        // Multi-cycle RAW on x7
        idle(); mc_issue_e = 1; rd_e = 7; #2;
        check("raw_issue_ctl", 32'(ctl_act()), 32'h0); tick();
        for (int k = 0; k < 2; k++) begin
            idle(); rs2_d = 7; #2;
            check("raw_count", 32'(mc_outstanding), 32'd1);
            check("raw_stall", 32'(ctl_act()), 32'(7'b1100010)); tick();
        end
        idle(); rs2_d = 7; mc_done = 1; mc_rd = 7; #2;
        check("raw_done_cycle", 32'(ctl_act()), 32'(7'b1100010)); tick();
        idle(); rs2_d = 7; #2;
        check("raw_released", 32'(ctl_act()), 32'h0);
        check("raw_count_zero", 32'(mc_outstanding), 32'd0); tick();

        // Structural limit
        idle(); mc_issue_e = 1; rd_e = 3; tick();
        idle(); mc_issue_e = 1; rd_e = 4; #2;
        check("struct_count1", 32'(mc_outstanding), 32'd1); tick();
        idle(); mc_op_d = 1; #2;
        check("struct_count2", 32'(mc_outstanding), 32'd2);
        check("struct_stall", 32'(ctl_act()), 32'(7'b1100010)); tick();
        idle(); mc_op_d = 1; mc_done = 1; mc_rd = 3; #2;
        check("struct_clear", 32'(ctl_act()), 32'h0); tick();
        idle(); mc_issue_e = 1; rd_e = 5; tick();
        idle(); #2;
        check("struct_count_after", 32'(mc_outstanding), 32'd2); tick();
        idle(); mc_done = 1; mc_rd = 4; tick();
        idle(); mc_done = 1; mc_rd = 5; tick();
        idle(); #2;
        check("struct_drained", 32'(mc_outstanding), 32'd0); tick();

        // Memory-wait freeze with redirect and issue pending
        for (int k = 0; k < 3; k++) begin
            idle(); mem_wait_m = 1; pc_src_e = 2'b01; mc_issue_e = 1; rd_e = 8; #2;
            check("freeze_ctl", 32'(ctl_act()), 32'(7'b1111001));
            check("freeze_count", 32'(mc_outstanding), 32'd0); tick();
        end
        idle(); pc_src_e = 2'b01; mc_issue_e = 1; rd_e = 8; #2;
        check("freeze_drop_ctl", 32'(ctl_act()), 32'(7'b0000110));
        check("freeze_drop_count", 32'(mc_outstanding), 32'd0); tick();
        idle(); rs1_d = 8; #2;
        check("freeze_issue_pend", 32'(ctl_act()), 32'(7'b1100010));
        check("freeze_issue_count", 32'(mc_outstanding), 32'd1); tick();
        idle(); mc_done = 1; mc_rd = 8; tick();

        // Spurious completion and reset mid-operation
        idle(); mc_done = 1; mc_rd = 9; #2;
        check("err_before", 32'(sb_error), 32'd0); tick();
        idle(); #2;
        check("err_set", 32'(sb_error), 32'd1);
        check("err_count", 32'(mc_outstanding), 32'd0); tick();
        idle(); mc_issue_e = 1; rd_e = 10; tick();
        idle(); rst = 1; #2;
        check("pre_rst_count", 32'(mc_outstanding), 32'd1); tick();
        rst = 0; idle(); rs1_d = 10; #2;
        check("rst_err", 32'(sb_error), 32'd0);
        check("rst_count", 32'(mc_outstanding), 32'd0);
        check("rst_bits", 32'(ctl_act()), 32'h0); tick();
        idle(); mc_done = 1; mc_rd = 10; tick();
        idle(); #2;
        check("late_done_err", 32'(sb_error), 32'd1);
        rst = 1; tick(); rst = 0;

`ifdef CPU_HAZARD_PERF_EN
        idle(); #2;
        check("perf_reset", perf_stall_cycles | perf_flush_cycles, 32'd0);
        for (int k = 0; k < 4; k++) begin
            idle(); result_src_e = 2'b01; rd_e = 3; rs1_d = 3; tick();
        end
        idle(); pc_src_e = 2'b01; tick();
        idle(); #2;
        check("perf_stall", perf_stall_cycles, 32'd4);
        check("perf_flush", perf_flush_cycles, 32'd5);
`endif

        // Randomized traffic against the model
        idle(); rst = 1; tick(); rst = 0;
        inflight.delete();
        err_m = 1'b0;
        for (int n = 0; n < 3000; n++) random_cycle(n);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
